// File: rtl/apb_fanout_decoder.sv
// APB 1-to-NUM_SLV fan-out: decodes the upstream address onto one downstream
// completer, bridges the SETUP/ACCESS phases and returns a registered response.
module apb_fanout_decoder #(
  parameter int                          NUM_SLV     = 4,
  parameter int                          ADDR_W      = 32,
  parameter int                          DATA_W      = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE    = {32'h0000_3000, 32'h0000_2000,
                                                        32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK    = {4{32'hFFFF_F000}},
  parameter int unsigned                 TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           s_paddr,
  input  logic                        s_psel,
  input  logic                        s_penable,
  input  logic                        s_pwrite,
  input  logic [DATA_W-1:0]           s_pwdata,
  output logic                        s_pready,
  output logic                        s_pslverr,
  output logic [DATA_W-1:0]           s_prdata,
  output logic [ADDR_W-1:0]           m_paddr,
  output logic [DATA_W-1:0]           m_pwdata,
  output logic                        m_pwrite,
  output logic                        m_penable,
  output logic [NUM_SLV-1:0]          m_psel,
  input  logic [NUM_SLV-1:0]          m_pready,
  input  logic [NUM_SLV-1:0]          m_pslverr,
  input  logic [NUM_SLV*DATA_W-1:0]   m_prdata,
  output logic [7:0]                  err_cnt,
  output logic                        busy
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYC == 32'd0) ? '0 : TMO_W'(TIMEOUT_CYC - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Returns {hit, index}; scanning downward lets the lowest matching index win.
  function automatic logic [IDX_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    return {hit, idx};
  endfunction

  function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SLV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                write_r;
  logic [IDX_W-1:0]    idx_r;
  logic [TMO_W-1:0]    tmo_cnt_r;

  logic [NUM_SLV-1:0]  psel_r;
  logic                penable_r;
  logic                pready_r;
  logic                pslverr_r;
  logic [DATA_W-1:0]   prdata_r;
  logic [7:0]          err_cnt_r;
  logic                busy_r;

  logic                req_s;
  logic                dec_hit_s;
  logic [IDX_W-1:0]    dec_idx_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic                sel_ready_s;
  logic                sel_err_s;
  logic [DATA_W-1:0]   sel_rdata_s;
  logic                tmo_hit_s;

  logic [NUM_SLV-1:0]  psel_nxt_s;
  logic                penable_nxt_s;
  logic                pready_nxt_s;
  logic                pslverr_nxt_s;
  logic [DATA_W-1:0]   prdata_nxt_s;
  logic                err_inc_s;

  assign req_s                  = s_psel & ~s_penable;
  assign {dec_hit_s, dec_idx_s} = decode(s_paddr);
  assign sel_idx_s              = (state_r == ST_IDLE) ? dec_idx_s : idx_r;
  assign sel_ready_s            = m_pready[idx_r];
  assign sel_err_s              = m_pslverr[idx_r];
  assign sel_rdata_s            = m_prdata[idx_r*DATA_W +: DATA_W];
  assign tmo_hit_s              = (TIMEOUT_CYC != 32'd0) && (tmo_cnt_r == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; pready is checked ahead of the timeout so it wins a tie.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = dec_hit_s ? ST_SETUP : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready_s || tmo_hit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: values the output registers take in the upcoming state.
  always_comb begin
    psel_nxt_s    = '0;
    penable_nxt_s = 1'b0;
    pready_nxt_s  = 1'b0;
    pslverr_nxt_s = 1'b0;
    prdata_nxt_s  = '0;
    err_inc_s     = 1'b0;
    case (state_nxt_s)
      ST_SETUP: begin
        psel_nxt_s = onehot(sel_idx_s);
      end
      ST_ACCESS: begin
        psel_nxt_s    = onehot(idx_r);
        penable_nxt_s = 1'b1;
      end
      ST_RESP: begin
        pready_nxt_s = 1'b1;
        if ((state_r == ST_ACCESS) && sel_ready_s) begin
          prdata_nxt_s  = sel_rdata_s;
          pslverr_nxt_s = sel_err_s;
        end else begin
          // Decode miss or ACCESS timeout.
          pslverr_nxt_s = 1'b1;
          err_inc_s     = 1'b1;
        end
      end
      default: begin
        psel_nxt_s = '0;
      end
    endcase
  end

  // Request capture while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      write_r <= 1'b0;
      idx_r   <= '0;
    end else if ((state_r == ST_IDLE) && req_s) begin
      addr_r  <= s_paddr;
      wdata_r <= s_pwdata;
      write_r <= s_pwrite;
      idx_r   <= dec_idx_s;
    end
  end

  // ACCESS-phase cycle counter for the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_ACCESS) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Output registers and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_r    <= '0;
      penable_r <= 1'b0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
      busy_r    <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      psel_r    <= psel_nxt_s;
      penable_r <= penable_nxt_s;
      pready_r  <= pready_nxt_s;
      pslverr_r <= pslverr_nxt_s;
      prdata_r  <= prdata_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      if (err_inc_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign m_paddr   = addr_r;
  assign m_pwdata  = wdata_r;
  assign m_pwrite  = write_r;
  assign m_psel    = psel_r;
  assign m_penable = penable_r;
  assign s_pready  = pready_r;
  assign s_pslverr = pslverr_r;
  assign s_prdata  = prdata_r;
  assign err_cnt   = err_cnt_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_apb_fanout_decoder.sv
// Randomized bench for apb_fanout_decoder: a per-transfer cycle schedule model
// drives expectations that a negedge compare process checks every cycle.
module tb_apb_fanout_decoder;

  localparam int TMO = 16;

  logic          clk;
  logic          rst;
  logic [31:0]   s_paddr;
  logic          s_psel;
  logic          s_penable;
  logic          s_pwrite;
  logic [31:0]   s_pwdata;
  logic          s_pready;
  logic          s_pslverr;
  logic [31:0]   s_prdata;
  logic [31:0]   m_paddr;
  logic [31:0]   m_pwdata;
  logic          m_pwrite;
  logic          m_penable;
  logic [3:0]    m_psel;
  logic [3:0]    m_pready;
  logic [3:0]    m_pslverr;
  logic [127:0]  m_prdata;
  logic [7:0]    err_cnt;
  logic          busy;

  apb_fanout_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .s_paddr   (s_paddr),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_pwdata  (s_pwdata),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr),
    .s_prdata  (s_prdata),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pwrite  (m_pwrite),
    .m_penable (m_penable),
    .m_psel    (m_psel),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .m_prdata  (m_prdata),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [3:0]  exp_psel;
  logic        exp_penable, exp_pready, exp_slverr, exp_busy, exp_pwrite;
  logic [31:0] exp_prdata, exp_paddr, exp_pwdata;
  int          model_err = 0;

  int          obs_cycle;
  logic [31:0] obs_rd;
  logic        obs_err;
  logic [3:0]  obs_psel;
  bit          obs_wd_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_exp();
    exp_psel = 4'd0; exp_penable = 1'b0; exp_pready = 1'b0; exp_slverr = 1'b0;
    exp_busy = 1'b0; exp_prdata = 32'd0; exp_paddr = 32'd0; exp_pwdata = 32'd0;
    exp_pwrite = 1'b0;
  endtask

  task automatic noise();
    m_pready  = 4'($urandom);
    m_pslverr = 4'($urandom);
    for (int p = 0; p < 4; p++) m_prdata[p*32 +: 32] = $urandom;
  endtask

  // Every-cycle comparison against the schedule model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_pready",  32'(s_pready),  32'(exp_pready));
      chk("s_prdata",  s_prdata,       exp_prdata);
      chk("s_pslverr", 32'(s_pslverr), 32'(exp_slverr));
      chk("m_psel",    32'(m_psel),    32'(exp_psel));
      chk("m_penable", 32'(m_penable), 32'(exp_penable));
      chk("busy",      32'(busy),      32'(exp_busy));
      chk("err_cnt",   32'(err_cnt),   32'(model_err));
      if (exp_psel != 4'd0) begin
        chk("m_paddr",  m_paddr,        exp_paddr);
        chk("m_pwdata", m_pwdata,       exp_pwdata);
        chk("m_pwrite", 32'(m_pwrite),  32'(exp_pwrite));
      end
    end
  end

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0; s_paddr = $urandom;
      noise();
      idle_exp();
    end
  endtask

  // One upstream transfer; cycle 0 is the setup cycle. Wait w = cycles the
  // target holds pready low in ACCESS. abort_k>0 pulses rst at that cycle.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int w, input bit fix, input logic [31:0] fix_rd,
                          input logic fix_err, input int abort_k);
    bit hit, tmo, aborted;
    int idx, fin;
    logic [31:0] cap_rd;
    logic cap_err;
    hit = (addr[31:14] == 18'd0);
    idx = int'(addr[13:12]);
    tmo = hit && (w >= TMO);
    fin = !hit ? 1 : (tmo ? 2 + TMO : 3 + w);
    cap_rd = 32'd0; cap_err = 1'b0; aborted = 1'b0;
    obs_cycle = -1; obs_rd = 32'd0; obs_err = 1'b0; obs_psel = 4'd0; obs_wd_bad = 1'b0;
    for (int k = 0; k <= fin; k++) begin
      @(posedge clk); #1;
      s_psel = 1'b1; s_penable = (k != 0); s_paddr = addr; s_pwrite = wr; s_pwdata = wd;
      noise();
      if (hit) begin
        m_pready[idx] = !tmo && (k == 2 + w);
        if (fix) begin
          m_prdata[idx*32 +: 32] = fix_rd;
          m_pslverr[idx] = fix_err;
        end
        if (!tmo && (k == 2 + w)) begin
          cap_rd  = m_prdata[idx*32 +: 32];
          cap_err = m_pslverr[idx];
        end
      end
      idle_exp();
      if ((abort_k > 0) && (k == abort_k)) begin
        rst = 1'b1; s_psel = 1'b0; s_penable = 1'b0; model_err = 0;
        #1;
        chk("rst_now_pready", 32'(s_pready), 32'd0);
        chk("rst_now_psel",   32'(m_psel),   32'd0);
        chk("rst_now_busy",   32'(busy),     32'd0);
        chk("rst_now_errcnt", 32'(err_cnt),  32'd0);
        aborted = 1'b1;
        break;
      end
      if (hit && (k >= 1) && (k < fin)) begin
        exp_psel = 4'b0001 << idx; exp_penable = (k >= 2); exp_busy = 1'b1;
        exp_paddr = addr; exp_pwdata = wd; exp_pwrite = wr;
      end
      if (k == fin) begin
        exp_pready = 1'b1; exp_busy = 1'b1;
        if (!hit || tmo) begin
          exp_slverr = 1'b1; exp_prdata = 32'd0;
          if (model_err < 255) model_err++;
        end else begin
          exp_slverr = cap_err; exp_prdata = cap_rd;
        end
      end
      #5;
      if (s_pready) begin
        obs_cycle = k; obs_rd = s_prdata; obs_err = s_pslverr;
      end
      obs_psel = obs_psel | m_psel;
      if ((m_psel != 4'd0) && (m_pwdata != wd)) obs_wd_bad = 1'b1;
    end
    if (aborted) begin
      @(posedge clk); #1; idle_exp();
      @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int w, r;
    rst = 1'b1; s_paddr = 32'd0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_pwdata = 32'd0; m_pready = 4'd0; m_pslverr = 4'd0; m_prdata = 128'd0;
    idle_exp();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    idle_cyc(2);

    // Zero-wait read from port 2.
    run_xfer(32'h0000_2004, 1'b0, 32'd0, 0, 1'b1, 32'hA5A5_0002, 1'b0, 0);
    chk("rd_p2_cycle", 32'(obs_cycle), 32'd3);
    chk("rd_p2_data",  obs_rd, 32'hA5A5_0002);
    chk("rd_p2_err",   32'(obs_err), 32'd0);
    chk("rd_p2_psel",  32'(obs_psel), 32'h4);
    idle_cyc(1);

    // Write to port 0 with 3 wait states.
    run_xfer(32'h0000_0010, 1'b1, 32'h0000_1234, 3, 1'b0, 32'd0, 1'b0, 0);
    chk("wr_p0_cycle", 32'(obs_cycle), 32'd6);
    chk("wr_p0_wdata", 32'(obs_wd_bad), 32'd0);
    chk("wr_p0_psel",  32'(obs_psel), 32'h1);
    idle_cyc(1);

    // Decode miss.
    run_xfer(32'h0000_9000, 1'b0, 32'd0, 0, 1'b0, 32'd0, 1'b0, 0);
    chk("miss_cycle",  32'(obs_cycle), 32'd1);
    chk("miss_err",    32'(obs_err), 32'd1);
    chk("miss_psel",   32'(obs_psel), 32'd0);
    chk("miss_errcnt", 32'(err_cnt), 32'd1);
    idle_cyc(1);

    // Port 1 never ready: 16 ACCESS cycles then timeout.
    run_xfer(32'h0000_1100, 1'b0, 32'd0, 1000, 1'b0, 32'd0, 1'b0, 0);
    chk("tmo_cycle",  32'(obs_cycle), 32'd18);
    chk("tmo_err",    32'(obs_err), 32'd1);
    chk("tmo_data",   obs_rd, 32'd0);
    chk("tmo_errcnt", 32'(err_cnt), 32'd2);
    idle_cyc(1);

    // Pready on the last allowed ACCESS cycle completes normally.
    run_xfer(32'h0000_1200, 1'b0, 32'd0, TMO - 1, 1'b1, 32'h0BAD_F00D, 1'b0, 0);
    chk("edge_cycle", 32'(obs_cycle), 32'd18);
    chk("edge_data",  obs_rd, 32'h0BAD_F00D);
    chk("edge_err",   32'(obs_err), 32'd0);

    // Port 3 slave error is forwarded without counting.
    run_xfer(32'h0000_3008, 1'b0, 32'd0, 1, 1'b1, 32'h0000_0033, 1'b1, 0);
    chk("p3err_err",    32'(obs_err), 32'd1);
    chk("p3err_errcnt", 32'(err_cnt), 32'd2);

    // Address range boundaries.
    run_xfer(32'h0000_3FFC, 1'b1, $urandom, 0, 1'b0, 32'd0, 1'b0, 0);
    chk("bnd_hi_psel", 32'(obs_psel), 32'h8);
    run_xfer(32'h0000_4000, 1'b0, 32'd0, 0, 1'b0, 32'd0, 1'b0, 0);
    chk("bnd_miss_err", 32'(obs_err), 32'd1);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 7) ? {18'd0, 2'($urandom), 12'($urandom)} : $urandom;
      r = $urandom_range(0, 9);
      w = (r < 6) ? $urandom_range(0, 4) : ((r < 8) ? TMO - 1 + $urandom_range(0, 1) : $urandom_range(17, 20));
      run_xfer(a, 1'($urandom), $urandom, w, 1'b0, 32'd0, 1'b0, 0);
      idle_cyc($urandom_range(0, 2));
    end

    // Reset during ACCESS aborts without a response.
    run_xfer(32'h0000_1000, 1'b0, 32'd0, 1000, 1'b0, 32'd0, 1'b0, 4);
    idle_cyc(4);
    for (int i = 0; i < 300; i++) begin
      run_xfer(32'h0000_9000 + 32'(i), 1'b0, 32'd0, 0, 1'b0, 32'd0, 1'b0, 0);
    end
    idle_cyc(2);
    chk("err_saturate", 32'(err_cnt), 32'd255);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
